oled_seq_ctrl: RTL

//  Parametrised top-level sequencer for the OLED voltmeter. Runs the display-init engine once, then sweeps N_CH ADC/display channels

---
 rtl/oled_pkg.sv | 21 ++
 rtl/oled_cyc_timer.sv | 41 ++++
 rtl/oled_seq_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared types and helpers for the OLED voltmeter sequencer.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    OPER  = 3'd2,
    ADV   = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } seq_state_e;

  localparam int SWEEP_W = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oled_cyc_timer.sv
// Loadable down counter with terminal-count flag; load has priority over clear.
module oled_cyc_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, clear, or count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/oled_seq_ctrl.sv
// OLED voltmeter sequencer: one display init, then per-channel sweeps, shared SPI bus mux.
// Define OLED_SEQ_WDT_EN to add the INIT/OPER watchdog with bounded retry and FAULT state.
module oled_seq_ctrl
  import oled_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int REFRESH_CYC = 1_000_000,
  parameter int WDT_CYC     = 2_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cont,
  input  logic               restart,
  output logic               init_en,
  input  logic               init_fin,
  input  logic               init_sclk,
  input  logic               init_sdo,
  output logic               oper_en,
  output logic [CH_W-1:0]    oper_ch,
  input  logic               oper_fin,
  input  logic               oper_sclk,
  input  logic               oper_sdo,
  input  logic               oper_dc,
  output logic               sclk,
  output logic               sdo,
  output logic               dc,
  output logic               busy,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               err
);

  localparam int              GAP_W    = cnt_width(REFRESH_CYC);
  localparam logic [GAP_W-1:0] GAP_LOAD = (REFRESH_CYC > 0) ? GAP_W'(REFRESH_CYC - 1) : '0;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  seq_state_e         state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic               init_en_q, oper_en_q, busy_q;
  logic               gap_tc_s, timeout_s, retry_max_s, sweep_done_s;

  assign sweep_done_s = (state_q == OPER) && oper_fin && (ch_q == LAST_CH);

  oled_cyc_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == IDLE),
    .load     ((state_d == GAP) && (state_q != GAP)),
    .load_val (GAP_LOAD),
    .tc       (gap_tc_s)
  );

  // Sequencer next state; a finish always beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        state_d = INIT;
        ch_d    = '0;
      end
      INIT: begin
        if (init_fin) begin
          state_d = OPER;
          ch_d    = '0;
        end else if (timeout_s) begin
          state_d = retry_max_s ? FAULT : IDLE;
        end else begin
          state_d = INIT;
        end
      end
      OPER: begin
        if (oper_fin && (ch_q != LAST_CH)) begin
          state_d = ADV;
        end else if (oper_fin) begin
          sweep_d = sweep_q + SWEEP_W'(1);
          ch_d    = '0;
          state_d = cont ? GAP : DONE;
        end else if (timeout_s) begin
          ch_d    = '0;
          state_d = retry_max_s ? FAULT : IDLE;
        end else begin
          state_d = OPER;
        end
      end
      ADV: begin
        ch_d    = ch_q + CH_W'(1);
        state_d = OPER;
      end
      GAP: begin
        if (gap_tc_s) begin
          state_d = OPER;
        end else begin
          state_d = GAP;
        end
      end
      DONE, FAULT: begin
        if (restart) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // State, counters and enables; enables are decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      sweep_q   <= '0;
      init_en_q <= 1'b0;
      oper_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      sweep_q   <= sweep_d;
      init_en_q <= (state_d == INIT);
      oper_en_q <= (state_d == OPER);
      busy_q    <= !(state_d inside {IDLE, DONE, FAULT});
    end
  end

`ifdef OLED_SEQ_WDT_EN
  localparam int                WDT_W     = cnt_width(WDT_CYC);
  localparam logic [WDT_W-1:0]  WDT_LOAD  = (WDT_CYC > 0) ? WDT_W'(WDT_CYC - 1) : '0;
  localparam int                RETRY_W   = cnt_width(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  logic               wdt_tc_s;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               err_q;

  // Reloaded on every entry to INIT or OPER, including ADV->OPER and GAP->OPER.
  oled_cyc_timer #(.W(WDT_W)) u_wdt_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == IDLE),
    .load     (((state_d == INIT) && (state_q != INIT)) ||
               ((state_d == OPER) && (state_q != OPER))),
    .load_val (WDT_LOAD),
    .tc       (wdt_tc_s)
  );

  assign timeout_s   = wdt_tc_s && (((state_q == INIT) && !init_fin) ||
                                    ((state_q == OPER) && !oper_fin));
  assign retry_max_s = (retry_q == RETRY_LIM);

  // Retry count: cleared by a completed sweep or a FAULT restart.
  always_comb begin
    retry_d = retry_q;
    if ((state_q == FAULT) && restart) begin
      retry_d = '0;
    end else if (sweep_done_s) begin
      retry_d = '0;
    end else if (timeout_s && !retry_max_s) begin
      retry_d = retry_q + RETRY_W'(1);
    end else begin
      retry_d = retry_q;
    end
  end

  // Retry and sticky fault registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      retry_q <= retry_d;
      err_q   <= (state_d == FAULT);
    end
  end

  assign err = err_q;
`else
  assign timeout_s   = 1'b0;
  assign retry_max_s = 1'b0;
  assign err         = 1'b0;
`endif

  // Bus mux follows the engine that owns the current state, idle-low otherwise.
  always_comb begin
    sclk = 1'b0;
    sdo  = 1'b0;
    dc   = 1'b0;
    case (state_q)
      INIT: begin
        sclk = init_sclk;
        sdo  = init_sdo;
      end
      OPER: begin
        sclk = oper_sclk;
        sdo  = oper_sdo;
        dc   = oper_dc;
      end
      default: begin
        sclk = 1'b0;
        sdo  = 1'b0;
        dc   = 1'b0;
      end
    endcase
  end

  assign init_en   = init_en_q;
  assign oper_en   = oper_en_q;
  assign oper_ch   = ch_q;
  assign busy      = busy_q;
  assign sweep_cnt = sweep_q;

endmodule
